// File: rtl/gpio_subsys_pkg.sv
// Shared widths, arbiter state encoding and the round-robin tie-break helper
// used by the GPIO bus arbiter.
package gpio_subsys_pkg;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Winner index; a tie goes to the master that did not win last time.
   function automatic logic pick_winner(input logic v0, input logic v1, input logic last);
      if (v0 && v1) begin
         return ~last;
      end
      return ~v0;
   endfunction

endpackage

// File: rtl/gpio_bus_arb_timer.sv
// Slave wait counter for one BUSY transfer: clear wins over enable, expired_o is
// combinational from the count; no backpressure. TIMEOUT_CYCLES of 0 never expires.
module gpio_bus_arb_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/gpio_bus_arb.sv
// Two-master round-robin arbiter for the GPIO slave bus: one IDLE cycle to latch, then
// BUSY until slave ready (combinational completion) or timeout; masters hold valid until ready.
module gpio_bus_arb
   import gpio_subsys_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              m0_valid,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ready,
   output logic              m0_err,
   input  logic              m1_valid,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ready,
   output logic              m1_err,
   output logic              s_valid,
   output logic [ADDR_W-1:0] s_addr,
   output logic              s_write,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ready,
   output logic [1:0]        grant
);

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              win;
   logic              done;
   logic              tmr_expired;
   logic [DATA_W-1:0] rsp_rdata;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      win     = pick_winner(m0_valid, m1_valid, last_q);
      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               state_d = BUSY;
               owner_d = win;
               last_d  = win;
               addr_d  = win ? m1_addr  : m0_addr;
               write_d = win ? m1_write : m0_write;
               wdata_d = win ? m1_wdata : m0_wdata;
               wstrb_d = win ? m1_wstrb : m0_wstrb;
            end
         end
         BUSY: begin
            if (s_ready || tmr_expired) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   gpio_bus_arb_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .clr_i    (state_q == IDLE),
      .en_i     ((state_q == BUSY) && !s_ready),
      .expired_o(tmr_expired)
   );

   // A real slave response on the timeout cycle takes precedence over the error.
   assign done      = (state_q == BUSY) && (s_ready || tmr_expired);
   assign rsp_rdata = s_ready ? s_rdata : ERR_RDATA;

   assign m0_ready = done && !owner_q;
   assign m1_ready = done && owner_q;
   assign m0_err   = m0_ready && !s_ready;
   assign m1_err   = m1_ready && !s_ready;
   assign m0_rdata = m0_ready ? rsp_rdata : '0;
   assign m1_rdata = m1_ready ? rsp_rdata : '0;

   assign s_valid = (state_q == BUSY);
   assign s_addr  = addr_q;
   assign s_write = write_q;
   assign s_wdata = wdata_q;
   assign s_wstrb = wstrb_q;
   assign grant   = (state_q == BUSY) ? {owner_q, ~owner_q} : 2'b00;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Randomized scoreboard bench for gpio_bus_arb: the driver predicts each transfer,
// a negedge monitor compares every cycle of DUT output against the queue head.
module tb_gpio_bus_arb;

   localparam int          TO  = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        m0_valid, m0_write, m0_ready, m0_err;
   logic [23:0] m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_valid, m1_write, m1_ready, m1_err;
   logic [23:0] m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_valid, s_write, s_ready;
   logic [23:0] s_addr;
   logic [31:0] s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;

   gpio_bus_arb #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
      .s_valid(s_valid), .s_addr(s_addr), .s_write(s_write), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      int          win;
      logic [23:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        err;
      logic [31:0] rdata;
      int          push_cyc;
      int          done_cyc;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   bit          pend[2];
   logic [23:0] p_addr[2];
   logic        p_wr[2];
   logic [31:0] p_wdata[2];
   logic [3:0]  p_wstrb[2];
   int          last_win = 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic new_req(input int i, input logic [23:0] a, input logic w,
                          input logic [31:0] wd, input logic [3:0] ws);
      pend[i] = 1'b1; p_addr[i] = a; p_wr[i] = w; p_wdata[i] = wd; p_wstrb[i] = ws;
   endtask

   task automatic drive_masters(input int cidx);
      m0_valid = pend[0]; m0_addr = p_addr[0]; m0_write = p_wr[0];
      m0_wdata = p_wdata[0]; m0_wstrb = p_wstrb[0];
      m1_valid = pend[1]; m1_addr = p_addr[1]; m1_write = p_wr[1];
      m1_wdata = p_wdata[1]; m1_wstrb = p_wstrb[1];
      if (cidx == 0) begin
         m0_valid = 1'($urandom); m0_addr = 24'($urandom); m0_write = 1'($urandom);
         m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      end
      if (cidx == 1) begin
         m1_valid = 1'($urandom); m1_addr = 24'($urandom); m1_write = 1'($urandom);
         m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      end
   endtask

   // Starts and ends just after a rising edge. d = slave wait cycles before s_ready.
   task automatic run_txn(input int d, input logic [31:0] rd, input bit corrupt);
      exp_t e;
      int   c;
      drive_masters(-1);
      s_ready = 1'($urandom);
      s_rdata = $urandom;
      e.win    = (pend[0] && pend[1]) ? 1 - last_win : (pend[0] ? 0 : 1);
      last_win = e.win;
      e.addr   = p_addr[e.win];
      e.wr     = p_wr[e.win];
      e.wdata  = p_wdata[e.win];
      e.wstrb  = p_wstrb[e.win];
      c        = (d + 1 <= TO) ? d + 1 : TO;
      e.err    = (d + 1 > TO);
      e.rdata  = e.err ? ERR : rd;
      e.push_cyc = cyc;
      e.done_cyc = cyc + c;
      q.push_back(e);
      for (int k = 1; k <= c; k++) begin
         @(posedge sys_clk); #1;
         drive_masters(corrupt ? e.win : -1);
         s_ready = (k == d + 1);
         s_rdata = (k == d + 1) ? rd : $urandom;
      end
      pend[e.win] = 1'b0;
      @(posedge sys_clk); #1;
   endtask

   task automatic gap(input int n, input bit force_rdy);
      for (int k = 0; k < n; k++) begin
         drive_masters(-1);
         s_ready = force_rdy ? 1'b1 : 1'($urandom);
         s_rdata = $urandom;
         @(posedge sys_clk); #1;
      end
   endtask

   always @(negedge sys_clk) begin : monitor
      bit   busy;
      int   own;
      exp_t e;
      if (!rst_n) begin
         check("rst_ctrl", 64'({grant, s_valid, m0_ready, m1_ready, m0_err, m1_err}), 64'd0);
         check("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'd0);
      end else begin
         busy = (q.size() > 0) && (cyc > q[0].push_cyc);
         own  = busy ? q[0].win : -1;
         check("s_valid", 64'(s_valid), 64'(busy));
         if (busy) begin
            check("grant", 64'(grant), (own == 0) ? 64'd1 : 64'd2);
            check("s_addr", 64'(s_addr), 64'(q[0].addr));
            check("s_write", 64'(s_write), 64'(q[0].wr));
            check("s_wdata", 64'(s_wdata), 64'(q[0].wdata));
            check("s_wstrb", 64'(s_wstrb), 64'(q[0].wstrb));
         end else begin
            check("grant_idle", 64'(grant), 64'd0);
         end
         if (own != 0) check("m0_quiet", 64'({m0_ready, m0_err, m0_rdata}), 64'd0);
         if (own != 1) check("m1_quiet", 64'({m1_ready, m1_err, m1_rdata}), 64'd0);
         if (m0_ready || m1_ready) begin
            if (q.size() == 0) begin
               check("unexpected_ready", 64'({m1_ready, m0_ready}), 64'd0);
            end else begin
               e = q.pop_front();
               check("ready_owner", 64'({m1_ready, m0_ready}), (e.win == 0) ? 64'd1 : 64'd2);
               check("ready_cycle", 64'(cyc), 64'(e.done_cyc));
               check("rsp_err", 64'(e.win == 0 ? m0_err : m1_err), 64'(e.err));
               check("rsp_rdata", 64'(e.win == 0 ? m0_rdata : m1_rdata), 64'(e.rdata));
            end
         end else if (q.size() > 0) begin
            check("ready_overdue", 64'(cyc > q[0].done_cyc), 64'd0);
            if (cyc > q[0].done_cyc) void'(q.pop_front());
         end
      end
   end

   initial begin
      exp_t r;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0; p_addr[i] = '0; p_wr[i] = 1'b0; p_wdata[i] = '0; p_wstrb[i] = '0;
      end
      drive_masters(-1);
      s_ready = 1'b0;
      s_rdata = '0;
      repeat (3) @(posedge sys_clk);
      #1 rst_n = 1'b1;
      @(negedge sys_clk);
      check("rst_s_fields", 64'({s_addr, s_write, s_wstrb}), 64'd0);
      check("rst_s_wdata", 64'(s_wdata), 64'd0);
      @(posedge sys_clk); #1;

      // Tie after reset goes to m0, then m1 (write, live fields scrambled), then m0 again.
      new_req(0, 24'h000010, 1'b0, 32'h0, 4'h0);
      new_req(1, 24'h000004, 1'b1, 32'hA5A5_A5A5, 4'b0011);
      run_txn(0, 32'h1234_5678, 1'b0);
      run_txn(0, 32'h0BAD_F00D, 1'b1);
      new_req(0, 24'h000020, 1'b0, 32'h0, 4'h0);
      new_req(1, 24'h000024, 1'b0, 32'h0, 4'h0);
      run_txn(0, 32'h1111_2222, 1'b0);
      run_txn(1, 32'h3333_4444, 1'b0);

      // Timeout, late slave ready in IDLE, then ready exactly on the timeout cycle.
      new_req(0, 24'h000030, 1'b0, 32'h0, 4'h0);
      run_txn(20, 32'h5555_6666, 1'b0);
      gap(4, 1'b1);
      new_req(0, 24'h000034, 1'b0, 32'h0, 4'h0);
      run_txn(TO - 1, 32'hCAFE_0001, 1'b0);

      for (int n = 0; n < 200; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 9) < 6)
               new_req(i, 24'($urandom), 1'($urandom), $urandom, 4'($urandom));
         end
         if (!pend[0] && !pend[1]) gap(1, 1'b0);
         else run_txn($urandom_range(0, 10), $urandom, $urandom_range(0, 3) == 0);
      end

      // Reset in the middle of a BUSY transfer: abandoned, arbitration state restarts.
      new_req(0, 24'h000040, 1'b0, 32'h0, 4'h0);
      drive_masters(-1);
      s_ready = 1'b0;
      r.win = 0; r.addr = p_addr[0]; r.wr = p_wr[0]; r.wdata = p_wdata[0]; r.wstrb = p_wstrb[0];
      r.err = 1'b1; r.rdata = ERR; r.push_cyc = cyc; r.done_cyc = cyc + TO;
      q.push_back(r);
      repeat (3) begin
         @(posedge sys_clk); #1;
      end
      rst_n = 1'b0;
      q.delete();
      pend[0] = 1'b0;
      last_win = 1;
      drive_masters(-1);
      repeat (2) @(posedge sys_clk);
      #1 rst_n = 1'b1;
      gap(5, 1'b1);
      new_req(0, 24'h000050, 1'b0, 32'h0, 4'h0);
      new_req(1, 24'h000054, 1'b1, 32'h7777_8888, 4'hF);
      run_txn(0, 32'h9999_AAAA, 1'b0);
      run_txn(2, 32'hBBBB_CCCC, 1'b0);
      gap(2, 1'b0);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
